// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage that owns the program counter.
//
// Upstream:
//   - A 32-bit next-PC 2-to-1 mux drives next_pc.
//   - pc_plus4 feeds back into that mux's i0 input.
//
// Instruction memory:
//   - One request at a time over a req/ack handshake.
//   - imem_addr always equals pc.
//
// Decode side:
//   - Fetched words are presented over a valid/stall handshake.
//   - A word consumed in the same cycle as a new ack is replaced directly,
//     which sustains one instruction per cycle against a zero-wait memory.
//
// Error detection:
//   - Timeout: a request left unacknowledged for IMEM_WAIT_MAX cycles parks
//     the unit in S_ERR with fetch_timeout set.
//   - Only reset or a redirect (pc_load) leaves S_ERR.
//
// Optional feature, macro PC_ALIGN_CHECK_EN:
//   - Defined: a redirect to a non-word-aligned target is refused. pc is
//     kept, pc_misalign is raised and the unit parks in S_ERR until an
//     aligned redirect arrives.
//   - Undefined: the low two target bits are dropped and pc_misalign is
//     tied low.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned PC_INC        = 4,
    parameter int unsigned IMEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        pc_load,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        fetch_timeout,
    output logic        pc_misalign
);

    // The wait counter only ever holds 0 .. IMEM_WAIT_MAX-1.
    localparam int unsigned CNT_W =
        (IMEM_WAIT_MAX < 2) ? 1 : $clog2(IMEM_WAIT_MAX);

    // Counter value on the last cycle a request may go unacknowledged.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_WAIT_MAX - 1);

    // Sequential fetch increment as a 32-bit addend.
    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,  // one quiet cycle after reset
        S_REQ  = 2'b01,  // fetching
        S_ERR  = 2'b10   // parked after timeout or refused redirect
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Redirect decode results.
    logic [31:0]      load_target;
    logic             load_ok;

    // Memory address, sequential successor and request qualification.
    // A held (stalled) instruction blocks new requests so that a returning
    // word never has to overwrite one decode has not taken yet.
    // NOTE: every signal written in an always_comb gets a value on every
    // path; a missed branch would make synthesis infer a latch.
    always_comb begin
        imem_addr = pc;
        pc_plus4  = pc + PC_STEP;  // wraps modulo 2^32
        imem_req  = (state == S_REQ) && !(inst_valid && stall);
    end

    // Redirect target qualification: refuse or realign low address bits.
    always_comb begin
`ifdef PC_ALIGN_CHECK_EN
        load_target = next_pc;
        load_ok     = (next_pc[1:0] == 2'b00);
`else
        load_target = next_pc & 32'hFFFF_FFFC;
        load_ok     = 1'b1;
`endif
    end

    // Fetch FSM with registered pc, instruction, valid and timeout outputs.
    // Priority inside S_REQ/S_ERR: redirect > accepted ack > consume/wait.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Reset wins over everything, including an ack in this cycle.
            state         <= S_IDLE;
            pc            <= RESET_PC;
            inst          <= 32'h0;
            inst_pc       <= 32'h0;
            inst_valid    <= 1'b0;
            fetch_timeout <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Redirects are ignored here; the request starts next.
                    state <= S_REQ;
                end

                S_REQ, S_ERR: begin
                    if (pc_load) begin
                        // A redirect discards the in-flight fetch and any
                        // ack arriving alongside it.
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
                        if (load_ok) begin
                            pc            <= load_target;
                            fetch_timeout <= 1'b0;
                            state         <= S_REQ;
                        end else begin
                            // Refused target: pc and timeout flag kept.
                            state <= S_ERR;
                        end
                    end else if (state == S_REQ) begin
                        if (imem_req && imem_ack) begin
                            // Capture; replaces a word consumed this cycle.
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc_plus4;
                            wait_cnt   <= '0;
                        end else begin
                            if (inst_valid && !stall) begin
                                inst_valid <= 1'b0;
                            end
                            // Only cycles with an outstanding request count.
                            if (imem_req) begin
                                if (wait_cnt == CNT_LAST) begin
                                    state         <= S_ERR;
                                    fetch_timeout <= 1'b1;
                                    inst_valid    <= 1'b0;
                                end else begin
                                    wait_cnt <= wait_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    // S_ERR without a redirect holds everything;
                    // inst_valid is already low there.
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Misalignment flag: set by a refused redirect, cleared by an accepted one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_misalign <= 1'b0;
        end else if (pc_load && (state != S_IDLE)) begin
            pc_misalign <= !load_ok;
        end
    end
`else
    assign pc_misalign = 1'b0;
`endif

endmodule
